// File: rtl/fb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fb_pkg                                                          |
// | Purpose  : Shared constants and helpers for the framebuffer access path.   |
// |            PIXEL_WIDTH is the nibble pixel size; word_width() returns the  |
// |            packed memory word width for a given pixels-per-word count.     |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package fb_pkg;

   localparam int PIXEL_WIDTH = 4;

   function automatic int word_width(input int pixels_per_word);
      return PIXEL_WIDTH * pixels_per_word;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fb_access_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fb_access_arbiter_if                                            |
// | Purpose  : Bundles the scanout, GPU write and framebuffer SRAM signals of  |
// |            fb_access_arbiter.                                              |
// | Modports : master - the arbiter (drives the SRAM bus, pixel, grants)       |
// |            slave  - the environment (VGA driver, GPU, SRAM macro)          |
// | Signals  : frame_next_pixel_in, frame_reset_in, frame_pixel_out,           |
// |            wr_valid_in, wr_ready_out, wr_addr_in, wr_data_in, wr_mask_in,  |
// |            mem_en_out, mem_we_out, mem_addr_out, mem_wdata_out,            |
// |            mem_wmask_out, mem_rdata_in, underflow_out                      |
// |            underflow_count_out only when FB_UNDERFLOW_COUNT_EN is defined  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface fb_access_arbiter_if
   import fb_pkg::*;
#(
   parameter int ADDR_WIDTH      = 15,
   parameter int PIXELS_PER_WORD = 2
);
   localparam int c_WORD_W = word_width(PIXELS_PER_WORD);

   logic                       frame_next_pixel_in;
   logic                       frame_reset_in;
   logic [PIXEL_WIDTH-1:0]     frame_pixel_out;

   logic                       wr_valid_in;
   logic                       wr_ready_out;
   logic [ADDR_WIDTH-1:0]      wr_addr_in;
   logic [c_WORD_W-1:0]        wr_data_in;
   logic [PIXELS_PER_WORD-1:0] wr_mask_in;

   logic                       mem_en_out;
   logic                       mem_we_out;
   logic [ADDR_WIDTH-1:0]      mem_addr_out;
   logic [c_WORD_W-1:0]        mem_wdata_out;
   logic [PIXELS_PER_WORD-1:0] mem_wmask_out;
   logic [c_WORD_W-1:0]        mem_rdata_in;

   logic                       underflow_out;
`ifdef FB_UNDERFLOW_COUNT_EN
   logic [7:0]                 underflow_count_out;
`endif

   modport master (
      input  frame_next_pixel_in, frame_reset_in,
      output frame_pixel_out,
      input  wr_valid_in, wr_addr_in, wr_data_in, wr_mask_in,
      output wr_ready_out,
      output mem_en_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_wmask_out,
      input  mem_rdata_in,
`ifdef FB_UNDERFLOW_COUNT_EN
      output underflow_count_out,
`endif
      output underflow_out
   );

   modport slave (
      output frame_next_pixel_in, frame_reset_in,
      input  frame_pixel_out,
      output wr_valid_in, wr_addr_in, wr_data_in, wr_mask_in,
      input  wr_ready_out,
      input  mem_en_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_wmask_out,
      output mem_rdata_in,
`ifdef FB_UNDERFLOW_COUNT_EN
      input  underflow_count_out,
`endif
      input  underflow_out
   );

endinterface
`default_nettype wire

// File: rtl/fb_prefetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fb_prefetch_fifo                                                |
// | Purpose  : Small synchronous FIFO holding prefetched framebuffer words.    |
// |            Flush has priority over push/pop; pop on empty and push on a    |
// |            full FIFO (without a matching pop) are ignored.                 |
// | Ports    : clk, rst_n       clock, async active-low reset                  |
// |            i_flush          discard all contents                           |
// |            i_push, i_data   write a word at the tail                       |
// |            i_pop            remove the head word                           |
// |            o_head           word at the head (undefined when empty)        |
// |            o_count          number of stored words                         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fb_prefetch_fifo #(
   parameter int DEPTH   = 4,
   parameter int WIDTH   = 8,
   parameter int COUNT_W = $clog2(DEPTH) + 1
) (
   input  wire logic               clk,
   input  wire logic               rst_n,
   input  wire logic               i_flush,
   input  wire logic               i_push,
   input  wire logic [WIDTH-1:0]   i_data,
   input  wire logic               i_pop,
   output logic      [WIDTH-1:0]   o_head,
   output logic      [COUNT_W-1:0] o_count
);
   localparam int                 c_PTR_W = $clog2(DEPTH);
   localparam logic [COUNT_W-1:0] c_DEPTH = COUNT_W'(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [COUNT_W-1:0] r_count;

   logic w_pop;
   logic w_push;

   assign w_pop  = i_pop && (r_count != '0);
   // A push into a full FIFO is only safe when the head leaves in the same cycle.
   assign w_push = i_push && ((r_count != c_DEPTH) || w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         if (w_push && !w_pop)      r_count <= r_count + COUNT_W'(1);
         else if (!w_push && w_pop) r_count <= r_count - COUNT_W'(1);
      end
   end

   // Storage needs no reset: count gates every use of the contents.
   always_ff @(posedge clk) begin
      if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fb_access_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fb_access_arbiter                                               |
// | Purpose  : Shares the single-port framebuffer SRAM between scanout reads   |
// |            (prefetched into a small FIFO and unpacked to nibble pixels)    |
// |            and GPU draw writes. Reads always win; writes take the idle     |
// |            slots.                                                          |
// | Ports    : clk, rst_n   clock, async active-low reset                      |
// |            bus          fb_access_arbiter_if.master: VGA pixel interface,  |
// |                         GPU write request, SRAM bus, underflow flag        |
// | Options  : FB_UNDERFLOW_COUNT_EN adds bus.underflow_count_out, an 8-bit    |
// |            saturating count of consumes seen with an empty FIFO.           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fb_access_arbiter
   import fb_pkg::*;
#(
   parameter int ADDR_WIDTH      = 15,
   parameter int PIXELS_PER_WORD = 2,
   parameter int FIFO_DEPTH      = 4,
   parameter int FRAME_WORDS     = 15000
) (
   input wire logic             clk,
   input wire logic             rst_n,
   fb_access_arbiter_if.master  bus
);
   localparam int c_WORD_W = word_width(PIXELS_PER_WORD);
   localparam int c_CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int c_PIX_W  = (PIXELS_PER_WORD > 1) ? $clog2(PIXELS_PER_WORD) : 1;

   localparam logic [c_PIX_W-1:0]    c_LAST_PIX  = c_PIX_W'(PIXELS_PER_WORD - 1);
   localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);
   localparam logic [c_CNT_W-1:0]    c_DEPTH     = c_CNT_W'(FIFO_DEPTH);

   // r_active holds the memory bus idle until the first clock after reset release.
   logic                  r_active;
   logic                  r_inflight;
   logic [ADDR_WIDTH-1:0] r_rd_addr;
   logic [c_PIX_W-1:0]    r_pix_idx;
   logic                  r_next_q;
   logic                  r_underflow;

   logic [c_CNT_W-1:0]    w_count;
   logic [c_WORD_W-1:0]   w_head;
   logic [c_CNT_W-1:0]    w_occupancy;
   logic                  w_empty;
   logic                  w_rd_req;
   logic                  w_wr_ready;
   logic                  w_wr_xfer;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_consume;
   logic [PIXEL_WIDTH-1:0] w_pixel;

   // Occupancy counts the word still in flight so the FIFO can never overflow.
   assign w_occupancy = w_count + c_CNT_W'(r_inflight);
   assign w_empty     = (w_count == '0);
   assign w_rd_req    = r_active && !bus.frame_reset_in && (w_occupancy < c_DEPTH);
   assign w_wr_ready  = r_active && !w_rd_req;
   assign w_wr_xfer   = bus.wr_valid_in && w_wr_ready;

   // Read data arriving during a frame reset belongs to the old frame.
   assign w_push      = r_inflight && !bus.frame_reset_in;
   assign w_consume   = bus.frame_next_pixel_in && !r_next_q && !bus.frame_reset_in;
   assign w_pop       = w_consume && !w_empty && (r_pix_idx == c_LAST_PIX);

   fb_prefetch_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .WIDTH   (c_WORD_W),
      .COUNT_W (c_CNT_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (bus.frame_reset_in),
      .i_push  (w_push),
      .i_data  (bus.mem_rdata_in),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_count)
   );

   always_comb begin
      bus.mem_en_out    = 1'b0;
      bus.mem_we_out    = 1'b0;
      bus.mem_addr_out  = '0;
      bus.mem_wdata_out = '0;
      bus.mem_wmask_out = '0;
      if (w_rd_req) begin
         bus.mem_en_out   = 1'b1;
         bus.mem_addr_out = r_rd_addr;
      end else if (w_wr_xfer) begin
         bus.mem_en_out    = 1'b1;
         bus.mem_we_out    = 1'b1;
         bus.mem_addr_out  = bus.wr_addr_in;
         bus.mem_wdata_out = bus.wr_data_in;
         bus.mem_wmask_out = bus.wr_mask_in;
      end
   end

   always_comb begin
      w_pixel = '0;
      for (int i = 0; i < PIXELS_PER_WORD; i++) begin
         if (!w_empty && (r_pix_idx == c_PIX_W'(i))) begin
            w_pixel = w_head[i*PIXEL_WIDTH +: PIXEL_WIDTH];
         end
      end
   end

   assign bus.frame_pixel_out = w_pixel;
   assign bus.wr_ready_out    = w_wr_ready;
   assign bus.underflow_out   = r_underflow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_active    <= 1'b0;
         r_inflight  <= 1'b0;
         r_rd_addr   <= '0;
         r_pix_idx   <= '0;
         r_next_q    <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_active   <= 1'b1;
         r_next_q   <= bus.frame_next_pixel_in;
         r_inflight <= w_rd_req;
         if (bus.frame_reset_in) begin
            r_rd_addr   <= '0;
            r_pix_idx   <= '0;
            r_underflow <= 1'b0;
         end else begin
            if (w_rd_req) begin
               r_rd_addr <= (r_rd_addr == c_LAST_ADDR) ? '0 : r_rd_addr + ADDR_WIDTH'(1);
            end
            if (w_consume) begin
               if (w_empty) begin
                  r_underflow <= 1'b1;
               end else begin
                  r_pix_idx <= (r_pix_idx == c_LAST_PIX) ? '0 : r_pix_idx + c_PIX_W'(1);
               end
            end
         end
      end
   end

`ifdef FB_UNDERFLOW_COUNT_EN
   logic [7:0] r_uf_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_uf_count <= '0;
      end else if (bus.frame_reset_in) begin
         r_uf_count <= '0;
      end else if (w_consume && w_empty && (r_uf_count != 8'hFF)) begin
         r_uf_count <= r_uf_count + 8'd1;
      end
   end

   assign bus.underflow_count_out = r_uf_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fb_access_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fb_access_arbiter                                            |
// | Purpose  : Self-checking bench for fb_access_arbiter with a behavioural    |
// |            SRAM and a pixel-stream reference model (pixel k of a frame is  |
// |            nibble k%2 of word (k/2)%FRAME_WORDS). Build with               |
// |            FB_UNDERFLOW_COUNT_EN to also check the underflow counter.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fb_access_arbiter;
   import fb_pkg::*;

   localparam int AW  = 15;
   localparam int PPW = 2;
   localparam int FW  = 8;
   localparam int WW  = PIXEL_WIDTH * PPW;
   localparam logic [7:0] INIT_W [8] = '{8'h21, 8'h43, 8'h65, 8'h87,
                                         8'hA9, 8'hCB, 8'hED, 8'h0F};

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fb_access_arbiter_if #(.ADDR_WIDTH(AW), .PIXELS_PER_WORD(PPW)) bus ();

   fb_access_arbiter #(
      .ADDR_WIDTH      (AW),
      .PIXELS_PER_WORD (PPW),
      .FIFO_DEPTH      (4),
      .FRAME_WORDS     (FW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural SRAM: request captured mid-cycle, executed on the next edge.
   logic [WW-1:0] sram    [32];
   logic [WW-1:0] ref_mem [32];
   logic          s_en = 1'b0, s_we = 1'b0;
   logic [4:0]    s_addr = '0;
   logic [WW-1:0] s_wd = '0;
   logic [PPW-1:0] s_wm = '0;
   logic          bd_en = 1'b0;
   logic [4:0]    bd_addr = '0;
   logic [WW-1:0] bd_data = '0;
   int            rd_log [$];

   always @(negedge clk) begin
      s_en   <= bus.mem_en_out;
      s_we   <= bus.mem_we_out;
      s_addr <= bus.mem_addr_out[4:0];
      s_wd   <= bus.mem_wdata_out;
      s_wm   <= bus.mem_wmask_out;
      if (rst_n && bus.mem_en_out && !bus.mem_we_out) rd_log.push_back(int'(bus.mem_addr_out));
   end

   always @(posedge clk) begin
      if (bd_en) begin
         sram[bd_addr] <= bd_data;
      end else if (s_en && s_we) begin
         for (int n = 0; n < PPW; n++)
            if (s_wm[n]) sram[s_addr][n*4 +: 4] <= s_wd[n*4 +: 4];
      end else if (s_en) begin
         bus.mem_rdata_in <= sram[s_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_pixel(input int k);
      logic [WW-1:0] w;
      w = ref_mem[(k / PPW) % FW];
      return 32'((w >> (4 * (k % PPW))) & 'hF);
   endfunction

   function automatic logic [WW-1:0] apply_mask(input logic [WW-1:0] old,
                                                input logic [WW-1:0] d,
                                                input logic [PPW-1:0] m);
      logic [WW-1:0] r;
      r = old;
      for (int n = 0; n < PPW; n++) if (m[n]) r[n*4 +: 4] = d[n*4 +: 4];
      return r;
   endfunction

   // One consume edge, then check the pixel that should now be presented.
   task automatic consume_check(input string tag, input int k);
      bus.frame_next_pixel_in = 1'b1;
      tick();
      bus.frame_next_pixel_in = 1'b0;
      #1;
      check(tag, 32'(bus.frame_pixel_out), exp_pixel(k));
      tick();
   endtask

   initial begin
      int w;
      int found;
      bus.frame_next_pixel_in = 1'b0;
      bus.frame_reset_in      = 1'b0;
      bus.wr_valid_in         = 1'b0;
      bus.wr_addr_in          = '0;
      bus.wr_data_in          = '0;
      bus.wr_mask_in          = '0;
      for (int i = 0; i < 32; i++) ref_mem[i] = '0;

      // Preload the frame through the SRAM backdoor while in reset.
      for (int i = 0; i < 8; i++) begin
         tick();
         bd_en = 1'b1; bd_addr = 5'(i); bd_data = INIT_W[i];
         ref_mem[i] = INIT_W[i];
      end
      tick();
      bd_en = 1'b0;
      bus.wr_valid_in = 1'b1;
      #1;
      check("rst_mem_en",    32'(bus.mem_en_out), 0);
      check("rst_wr_ready",  32'(bus.wr_ready_out), 0);
      check("rst_pixel",     32'(bus.frame_pixel_out), 0);
      check("rst_underflow", 32'(bus.underflow_out), 0);
      check("rst_mem_addr",  32'(bus.mem_addr_out), 0);
      bus.wr_valid_in = 1'b0;
      tick();
      rst_n = 1'b1;

      // Initial prefetch: four back-to-back reads from address 0.
      w = 0;
      tick();
      while (!bus.mem_en_out && w < 5) begin tick(); w++; end
      check("first_read_seen", 32'(bus.mem_en_out), 1);
      for (int a = 0; a < 4; a++) begin
         check("prefetch_en",   32'(bus.mem_en_out), 1);
         check("prefetch_we",   32'(bus.mem_we_out), 0);
         check("prefetch_addr", 32'(bus.mem_addr_out), 32'(a));
         tick();
      end
      check("full_mem_en",   32'(bus.mem_en_out), 0);
      check("full_wr_ready", 32'(bus.wr_ready_out), 1);
      tick();

      // Write granted in the same cycle while the FIFO is full.
      bus.wr_valid_in = 1'b1; bus.wr_addr_in = 15'h0010;
      bus.wr_data_in = 8'hA5; bus.wr_mask_in = 2'b10;
      #1;
      check("wr_ready",  32'(bus.wr_ready_out), 1);
      check("wr_mem_en", 32'(bus.mem_en_out), 1);
      check("wr_mem_we", 32'(bus.mem_we_out), 1);
      check("wr_addr",   32'(bus.mem_addr_out), 32'h10);
      check("wr_data",   32'(bus.mem_wdata_out), 32'hA5);
      check("wr_mask",   32'(bus.mem_wmask_out), 32'h2);
      ref_mem[16] = apply_mask(ref_mem[16], 8'hA5, 2'b10);
      tick();
      bus.wr_valid_in = 1'b0;
      #1;

      // Unpack order and refill.
      check("pixel_0", 32'(bus.frame_pixel_out), exp_pixel(0));
      for (int k = 1; k <= 3; k++) consume_check("pixel_unpack", k);
      check("refill_addr4", (rd_log.size() > 4) ? 32'(rd_log[4]) : 32'hFFFF, 4);

      // Run through a whole frame and watch the read address wrap.
      for (int k = 4; k <= 16; k++) consume_check("pixel_frame", k);
      repeat (3) tick();
      check("rd_log_size", 32'(rd_log.size()), 12);
      for (int i = 4; i < 12; i++)
         check("rd_wrap_addr", (rd_log.size() > i) ? 32'(rd_log[i]) : 32'hFFFF, 32'(i % FW));
      check("frame_no_underflow", 32'(bus.underflow_out), 0);

      // Frame reset, then a one-cycle reset while the read of address 2 is in flight.
      bus.frame_reset_in = 1'b1;
      tick(); tick();
      check("freset_pixel",    32'(bus.frame_pixel_out), 0);
      check("freset_wr_ready", 32'(bus.wr_ready_out), 1);
      check("freset_no_read",  32'(bus.mem_en_out), 0);
      bus.frame_reset_in = 1'b0;
      #1;
      w = 0; found = 0;
      while (!found && w < 10) begin
         if (bus.mem_en_out && !bus.mem_we_out && bus.mem_addr_out == 15'd2) found = 1;
         else begin tick(); w++; end
      end
      check("read2_seen", 32'(found), 1);
      tick();
      bus.frame_reset_in = 1'b1;
      tick();
      bus.frame_reset_in = 1'b0;
      #1;
      check("pulse_fifo_empty", 32'(bus.frame_pixel_out), 0);
      check("pulse_read_en",    32'(bus.mem_en_out), 1);
      check("pulse_read_addr0", 32'(bus.mem_addr_out), 0);

      // Consume one cycle after the fall while the FIFO is still empty.
      tick();
      bus.frame_next_pixel_in = 1'b1;
      #1;
      check("uf_pixel_zero", 32'(bus.frame_pixel_out), 0);
      tick();
      bus.frame_next_pixel_in = 1'b0;
      #1;
      check("uf_set", 32'(bus.underflow_out), 1);
`ifdef FB_UNDERFLOW_COUNT_EN
      check("uf_count_1", 32'(bus.underflow_count_out), 1);
`endif
      check("uf_pixel_after", 32'(bus.frame_pixel_out), exp_pixel(0));
      tick();
      for (int k = 1; k <= 4; k++) consume_check("post_pulse_pixel", k);
      bus.frame_reset_in = 1'b1;
      tick();
      check("uf_cleared", 32'(bus.underflow_out), 0);
`ifdef FB_UNDERFLOW_COUNT_EN
      check("uf_count_cleared", 32'(bus.underflow_count_out), 0);
`endif

      // Randomised frames: redraw during frame reset, then scan out with
      // irregular pixel timing and background writes outside the frame.
      for (int round = 0; round < 3; round++) begin
         bus.frame_reset_in = 1'b1;
         for (int j = 0; j < 12; j++) begin
            bus.wr_valid_in = 1'b1;
            bus.wr_addr_in  = 15'($urandom_range(0, FW - 1));
            bus.wr_data_in  = 8'($urandom);
            bus.wr_mask_in  = 2'($urandom);
            #1;
            check("rnd_draw_ready", 32'(bus.wr_ready_out), 1);
            check("rnd_draw_we",    32'(bus.mem_we_out), 1);
            ref_mem[bus.wr_addr_in[4:0]] =
               apply_mask(ref_mem[bus.wr_addr_in[4:0]], bus.wr_data_in, bus.wr_mask_in);
            tick();
         end
         bus.wr_valid_in    = 1'b0;
         bus.frame_reset_in = 1'b0;
         for (int j = 0; j < 10; j++) begin
            bus.wr_valid_in = 1'($urandom);
            bus.wr_addr_in  = 15'($urandom_range(8, 31));
            bus.wr_data_in  = 8'($urandom);
            bus.wr_mask_in  = 2'($urandom);
            #1;
            if (bus.wr_valid_in && bus.wr_ready_out) begin
               check("rnd_bg_addr", 32'(bus.mem_addr_out), 32'(bus.wr_addr_in));
               ref_mem[bus.wr_addr_in[4:0]] =
                  apply_mask(ref_mem[bus.wr_addr_in[4:0]], bus.wr_data_in, bus.wr_mask_in);
            end
            tick();
         end
         bus.wr_valid_in = 1'b0;
         #1;
         check("rnd_pixel_0", 32'(bus.frame_pixel_out), exp_pixel(0));
         w = 12 + int'($urandom_range(0, 20));
         for (int k = 1; k <= w; k++) begin
            consume_check("rnd_pixel", k);
            repeat ($urandom_range(0, 2)) tick();
         end
         check("rnd_no_underflow", 32'(bus.underflow_out), 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
